// File: rtl/phase_sequencer.sv
// One-hot phase sequencer (F/R/X/M/W) with fetch/data waits, halt handling and counters.
// Optional single-step support is enabled by defining PHASE_STEP_EN.
module phase_sequencer #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt_req,
    input  logic             imem_rdy,
    input  logic             dmem_req,
    input  logic             dmem_rdy,
`ifdef PHASE_STEP_EN
    input  logic             step_mode,
    input  logic             step,
`endif
    output logic [4:0]       phase,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_F,
        S_R,
        S_X,
        S_M,
        S_W,
        S_HALT
    } state_t;

    localparam logic [31:0] MAX_WAIT_L = 32'(MAX_WAIT);

    state_t      state, state_nxt;
    logic [31:0] wait_cnt;
    logic        halt_pending, halt_pending_nxt;
    logic        waiting, timeout, retire, go, stop_after_w, in_exec;

`ifdef PHASE_STEP_EN
    assign go           = run | step;
    assign stop_after_w = halt_pending | halt_req | step_mode;
`else
    assign go           = run;
    assign stop_after_w = halt_pending | halt_req;
`endif

    assign in_exec = (state != S_IDLE) && (state != S_HALT);

    always_comb begin
        state_nxt = state;
        waiting   = 1'b0;
        timeout   = 1'b0;
        retire    = 1'b0;
        case (state)
            S_IDLE: if (run) state_nxt = S_F;
            S_HALT: if (go) state_nxt = S_F;
            S_F: begin
                if (imem_rdy) state_nxt = S_R;
                else          waiting   = 1'b1;
            end
            S_R: state_nxt = S_X;
            S_X: state_nxt = S_M;
            S_M: begin
                if (!dmem_req || dmem_rdy) state_nxt = S_W;
                else                       waiting   = 1'b1;
            end
            S_W: begin
                retire    = 1'b1;
                state_nxt = stop_after_w ? S_HALT : S_F;
            end
            default: state_nxt = S_IDLE;
        endcase
        // The waiting cycle that brings the count up to MAX_WAIT is the last one.
        if (waiting && (MAX_WAIT_L != 32'd0) && ((wait_cnt + 32'd1) >= MAX_WAIT_L)) begin
            timeout   = 1'b1;
            state_nxt = S_HALT;
        end
    end

    always_comb begin
        halt_pending_nxt = halt_pending;
        if (state_nxt == S_HALT && state != S_HALT)
            halt_pending_nxt = 1'b0;
        else if (in_exec && halt_req)
            halt_pending_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            phase        <= '0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            err          <= 1'b0;
            instr_cnt    <= '0;
            stall_cnt    <= '0;
            halt_pending <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            halt_pending <= halt_pending_nxt;
            phase        <= '0;
            case (state_nxt)
                S_F:     phase <= 5'b00001;
                S_R:     phase <= 5'b00010;
                S_X:     phase <= 5'b00100;
                S_M:     phase <= 5'b01000;
                S_W:     phase <= 5'b10000;
                default: phase <= '0;
            endcase
            busy   <= (state_nxt != S_IDLE) && (state_nxt != S_HALT);
            halted <= (state_nxt == S_HALT);
            if (timeout)
                err <= 1'b1;
            else if (state == S_HALT && go)
                err <= 1'b0;
            if (retire)
                instr_cnt <= instr_cnt + CNT_W'(1);
            if (waiting)
                stall_cnt <= stall_cnt + CNT_W'(1);
            wait_cnt <= (waiting && state_nxt == state) ? wait_cnt + 32'd1 : '0;
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a default instance plus a MAX_WAIT=4 instance for timeout.
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, halt_req, imem_rdy, dmem_req, dmem_rdy;
    logic [4:0]  phase, phase_to;
    logic        busy, halted, err, busy_to, halted_to, err_to;
    logic [31:0] instr_cnt, stall_cnt, instr_cnt_to, stall_cnt_to;
    int          checks = 0;
    int          errors = 0;

    phase_sequencer #(.CNT_W(32), .MAX_WAIT(255)) dut (
        .clk(clk), .rst(rst), .run(run), .halt_req(halt_req),
        .imem_rdy(imem_rdy), .dmem_req(dmem_req), .dmem_rdy(dmem_rdy),
        .phase(phase), .busy(busy), .halted(halted), .err(err),
        .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
    );

    phase_sequencer #(.CNT_W(32), .MAX_WAIT(4)) dut_to (
        .clk(clk), .rst(rst), .run(run), .halt_req(halt_req),
        .imem_rdy(imem_rdy), .dmem_req(dmem_req), .dmem_rdy(dmem_rdy),
        .phase(phase_to), .busy(busy_to), .halted(halted_to), .err(err_to),
        .instr_cnt(instr_cnt_to), .stall_cnt(stall_cnt_to)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; halt_req = 1'b0;
        imem_rdy = 1'b0; dmem_req = 1'b0; dmem_rdy = 1'b0;
        #12;
        check("rst_phase", 32'(phase), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_icnt", instr_cnt, 32'd0);
        check("rst_scnt", stall_cnt, 32'd0);
        tick();
        rst = 1'b0;

        // Back-to-back instructions, no waits
        imem_rdy = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        check("seq_first_f", 32'(phase), 32'h01);
        check("seq_busy", 32'(busy), 32'h1);
        for (int k = 2; k <= 16; k++) begin
            tick();
            check($sformatf("seq_phase_%0d", k), 32'(phase), 32'h1 << ((k - 1) % 5));
        end
        check("seq_icnt3", instr_cnt, 32'd3);
        check("seq_scnt0", stall_cnt, 32'd0);

        // Fetch wait: F held 5 cycles total
        imem_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("fwait_f_%0d", k), 32'(phase), 32'h01);
        end
        check("fwait_scnt4", stall_cnt, 32'd4);
        imem_rdy = 1'b1;
        tick();
        check("fwait_r", 32'(phase), 32'h02);
        tick();
        check("fwait_x", 32'(phase), 32'h04);

        // Data wait: M held 4 cycles
        dmem_req = 1'b1; dmem_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("mwait_m_%0d", k), 32'(phase), 32'h08);
        end
        check("mwait_scnt7", stall_cnt, 32'd7);
        dmem_rdy = 1'b1;
        tick();
        check("mwait_w", 32'(phase), 32'h10);
        dmem_req = 1'b0; dmem_rdy = 1'b0;
        tick();
        check("mwait_f", 32'(phase), 32'h01);
        check("mwait_icnt4", instr_cnt, 32'd4);
        tick(); tick(); tick();
        check("nomem_m", 32'(phase), 32'h08);
        tick();
        check("nomem_w", 32'(phase), 32'h10);
        tick();
        check("nomem_f", 32'(phase), 32'h01);
        check("nomem_icnt5", instr_cnt, 32'd5);
        check("nomem_scnt7", stall_cnt, 32'd7);

        // Halt request pulsed during X
        tick(); tick();
        check("halt_x", 32'(phase), 32'h04);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("halt_m", 32'(phase), 32'h08);
        tick();
        check("halt_w", 32'(phase), 32'h10);
        tick();
        check("halt_phase0", 32'(phase), 32'h0);
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_busy", 32'(busy), 32'h0);
        check("halt_icnt6", instr_cnt, 32'd6);
        tick();
        check("halt_stays", 32'(halted), 32'h1);
        run = 1'b1;
        tick();
        run = 1'b0;
        check("resume_f", 32'(phase), 32'h01);
        check("resume_halted", 32'(halted), 32'h0);

        // Asynchronous reset during M
        tick(); tick(); tick();
        check("arst_pre_m", 32'(phase), 32'h08);
        #2;
        rst = 1'b1;
        #1;
        check("arst_phase", 32'(phase), 32'h0);
        check("arst_icnt", instr_cnt, 32'd0);
        check("arst_scnt", stall_cnt, 32'd0);
        check("arst_busy", 32'(busy), 32'h0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        check("arst_idle_phase", 32'(phase), 32'h0);
        check("arst_idle_busy", 32'(busy), 32'h0);

        // Timeout on stuck fetch (dut_to, MAX_WAIT=4)
        imem_rdy = 1'b0; run = 1'b1;
        tick();
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("to_f_%0d", k), 32'(phase_to), 32'h01);
        end
        tick();
        check("to_phase0", 32'(phase_to), 32'h0);
        check("to_halted", 32'(halted_to), 32'h1);
        check("to_err", 32'(err_to), 32'h1);
        check("to_scnt4", stall_cnt_to, 32'd4);
        check("to_icnt0", instr_cnt_to, 32'd0);
        check("nto_still_f", 32'(phase), 32'h01);
        check("nto_err", 32'(err), 32'h0);
        tick();
        check("to_err_sticky", 32'(err_to), 32'h1);

        // run + halt_req together in HALT: run wins, halt not latched
        run = 1'b1; halt_req = 1'b1; imem_rdy = 1'b1;
        tick();
        run = 1'b0; halt_req = 1'b0;
        check("to_resume_f", 32'(phase_to), 32'h01);
        check("to_resume_err", 32'(err_to), 32'h0);
        check("to_resume_halted", 32'(halted_to), 32'h0);
        tick(); tick(); tick(); tick();
        check("to_w", 32'(phase_to), 32'h10);
        tick();
        check("to_no_halt_f", 32'(phase_to), 32'h01);
        check("to_icnt1", instr_cnt_to, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
